// File: rtl/ascii_output.sv
// ascii_output: CPU transmit sink that drains ACIA-style TX bytes into a host-readable text buffer.
// Define ASCII_OUT_CRLF_EN to store CR as LF and discard LF on commit; otherwise bytes are stored verbatim.
module ascii_output #(
    parameter int DIVISOR = 4000,
    parameter int ADDR_W  = 16
) (
    input  logic              clk25,
    input  logic              rst,
    input  logic              cs,
    input  logic              we,
    input  logic              address,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    input  logic              ioctl_upload,
    input  logic [ADDR_W-1:0] textoutput_addr,
    output logic [7:0]        textoutput_dout,
    output logic [ADDR_W:0]   text_len,
    input  logic              text_clear,
    output logic              overflow
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIVISOR - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_COMMIT
    } state_t;

    state_t            r_state;
    logic              r_tdre;
    logic [7:0]        r_hold;
    logic [CNT_W-1:0]  r_tickCnt;
    logic [ADDR_W:0]   r_textLen;
    logic              r_overflow;
    logic [7:0]        r_dout;
    logic [7:0]        r_textDout;
    logic [7:0]        r_ram [DEPTH];

    logic              w_tick;
    logic              w_cpuWrite;
    logic              w_cpuRead;
    logic              w_full;
    logic              w_dropNewline;
    logic [7:0]        w_storeByte;
    logic              w_ramWe;

    assign w_tick     = (r_tickCnt == CNT_MAX);
    assign w_cpuWrite = cs & we & ~address;
    assign w_cpuRead  = cs & ~we;
    // The length MSB is only ever set when exactly DEPTH bytes are held, since the count saturates.
    assign w_full     = r_textLen[ADDR_W];

    always_comb begin
        w_storeByte   = r_hold;
        w_dropNewline = 1'b0;
`ifdef ASCII_OUT_CRLF_EN
        if (r_hold == 8'h0D) begin
            w_storeByte = 8'h0A;
        end else if (r_hold == 8'h0A) begin
            w_dropNewline = 1'b1;
        end
`endif
    end

    assign w_ramWe = (r_state == S_COMMIT) && !text_clear && !w_full && !w_dropNewline;

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            r_tickCnt <= '0;
        end else if (w_tick) begin
            r_tickCnt <= '0;
        end else begin
            r_tickCnt <= r_tickCnt + 1'b1;
        end
    end

    // text_clear outranks everything, including a write or commit landing in the same cycle.
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tdre     <= 1'b1;
            r_hold     <= 8'h00;
            r_textLen  <= '0;
            r_overflow <= 1'b0;
        end else if (text_clear) begin
            r_state    <= S_IDLE;
            r_tdre     <= 1'b1;
            r_textLen  <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cpuWrite) begin
                        r_hold  <= din;
                        r_tdre  <= 1'b0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_cpuWrite) begin
                        r_overflow <= 1'b1;
                    end
                    if (w_tick && !ioctl_upload) begin
                        r_state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    r_state <= S_IDLE;
                    r_tdre  <= 1'b1;
                    if (w_cpuWrite) begin
                        r_overflow <= 1'b1;
                    end
                    if (!w_dropNewline) begin
                        if (w_full) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_textLen <= r_textLen + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tdre  <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk25) begin
        if (w_ramWe) begin
            r_ram[r_textLen[ADDR_W-1:0]] <= w_storeByte;
        end
    end

    // Locations at or beyond the captured length read as zero, so stale RAM is never visible.
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            r_textDout <= 8'h00;
        end else if ({1'b0, textoutput_addr} < r_textLen) begin
            r_textDout <= r_ram[textoutput_addr];
        end else begin
            r_textDout <= 8'h00;
        end
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            r_dout <= 8'h00;
        end else if (w_cpuRead) begin
            r_dout <= address ? {2'b00, r_overflow, 3'b000, r_tdre, 1'b0} : 8'h00;
        end
    end

    assign dout            = r_dout;
    assign textoutput_dout = r_textDout;
    assign text_len        = r_textLen;
    assign overflow        = r_overflow;

endmodule

// File: tb/tb_ascii_output.sv
// tb_ascii_output: directed and randomized checks of ascii_output against a queue-based buffer model.
// Honours ASCII_OUT_CRLF_EN the same way the design does.
module tb_ascii_output;

    localparam int DIV   = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk25 = 1'b0;
    logic          rst;
    logic          cs;
    logic          we;
    logic          address;
    logic [7:0]    din;
    logic [7:0]    dout;
    logic          ioctl_upload;
    logic [AW-1:0] textoutput_addr;
    logic [7:0]    textoutput_dout;
    logic [AW:0]   text_len;
    logic          text_clear;
    logic          overflow;

    int testCount = 0;
    int failCount = 0;

    // Reference model: stored bytes, one pending TX byte and its scheduled commit edge.
    logic [7:0] mq[$];
    bit         mBusy;
    bit         mOvf;
    int         mCommitAt;
    logic [7:0] mHold;
    int         k;
    logic [7:0] expDout;
    logic [7:0] expTxt;
    bit         readDone;

    ascii_output #(.DIVISOR(DIV), .ADDR_W(AW)) dut (
        .clk25(clk25),
        .rst(rst),
        .cs(cs),
        .we(we),
        .address(address),
        .din(din),
        .dout(dout),
        .ioctl_upload(ioctl_upload),
        .textoutput_addr(textoutput_addr),
        .textoutput_dout(textoutput_dout),
        .text_len(text_len),
        .text_clear(text_clear),
        .overflow(overflow)
    );

    always #20 clk25 = ~clk25;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h (time %0t)", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mBusy     = 1'b0;
        mOvf      = 1'b0;
        mCommitAt = -1;
        mHold     = 8'h00;
        k         = 0;
        readDone  = 1'b0;
    endtask

    task automatic storeByte(input logic [7:0] b);
        logic [7:0] v;
        v = b;
`ifdef ASCII_OUT_CRLF_EN
        if (v == 8'h0A) return;
        if (v == 8'h0D) v = 8'h0A;
`endif
        if (mq.size() == DEPTH) mOvf = 1'b1;
        else mq.push_back(v);
    endtask

    task automatic modelStep();
        int lenPre;
        bit busyPre;
        bit ovfPre;
        bit tickNow;
        lenPre  = mq.size();
        busyPre = mBusy;
        ovfPre  = mOvf;
        tickNow = ((k % DIV) == DIV - 1);
        readDone = 1'b0;
        if (cs && !we) begin
            readDone = 1'b1;
            expDout  = address ? {2'b00, ovfPre, 3'b000, !busyPre, 1'b0} : 8'h00;
        end
        expTxt = (int'(textoutput_addr) < lenPre) ? mq[textoutput_addr] : 8'h00;
        if (text_clear) begin
            mq.delete();
            mOvf      = 1'b0;
            mBusy     = 1'b0;
            mCommitAt = -1;
        end else begin
            if (mBusy && mCommitAt == k) begin
                storeByte(mHold);
                mBusy     = 1'b0;
                mCommitAt = -1;
            end else if (mBusy && mCommitAt < 0 && tickNow && !ioctl_upload) begin
                mCommitAt = k + 1;
            end
            if (cs && we && !address) begin
                if (busyPre) mOvf = 1'b1;
                else begin
                    mBusy = 1'b1;
                    mHold = din;
                end
            end
        end
        k++;
    endtask

    task automatic stepClock();
        @(posedge clk25);
        modelStep();
        #1;
        checkOutput("text_len", 32'(text_len), 32'(mq.size()));
        checkOutput("overflow", 32'(overflow), 32'(mOvf));
        checkOutput("textoutput_dout", 32'(textoutput_dout), 32'(expTxt));
        if (readDone) checkOutput("dout", 32'(dout), 32'(expDout));
    endtask

    task automatic setIdle();
        cs         = 1'b0;
        we         = 1'b0;
        address    = 1'b0;
        din        = 8'h00;
        text_clear = 1'b0;
    endtask

    task automatic cpuWrite(input logic [7:0] data);
        cs = 1'b1; we = 1'b1; address = 1'b0; din = data;
        stepClock();
        setIdle();
    endtask

    task automatic cpuRead(input logic a);
        cs = 1'b1; we = 1'b0; address = a;
        stepClock();
        setIdle();
    endtask

    task automatic clearBuffer();
        text_clear = 1'b1;
        stepClock();
        text_clear = 1'b0;
    endtask

    task automatic waitTdre();
        int n;
        n = 0;
        while (mBusy && n < 4 * DIV) begin
            stepClock();
            n++;
        end
        checkOutput("wait_tdre", 32'(mBusy), 32'(0));
    endtask

    task automatic hostRead(input logic [AW-1:0] a);
        textoutput_addr = a;
        stepClock();
    endtask

    task automatic asyncReset();
        rst = 1'b1;
        setIdle();
        #5;
        checkOutput("rst_text_len", 32'(text_len), 32'(0));
        checkOutput("rst_overflow", 32'(overflow), 32'(0));
        checkOutput("rst_dout", 32'(dout), 32'(0));
        checkOutput("rst_textoutput_dout", 32'(textoutput_dout), 32'(0));
        modelReset();
        @(negedge clk25);
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input int cycles);
        int r;
        for (int i = 0; i < cycles; i++) begin
            if (i == cycles / 2) asyncReset();
            cs      = ($urandom_range(0, 3) == 0);
            we      = 1'($urandom_range(0, 1));
            address = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 7);
            din = (r == 0) ? 8'h0D : (r == 1) ? 8'h0A : 8'($urandom);
            text_clear = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 39) == 0) ioctl_upload = ~ioctl_upload;
            textoutput_addr = AW'($urandom_range(0, DEPTH - 1));
            stepClock();
        end
        setIdle();
        ioctl_upload = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        ioctl_upload    = 1'b0;
        textoutput_addr = '0;
        setIdle();
        modelReset();
        #50;
        checkOutput("reset_text_len", 32'(text_len), 32'(0));
        checkOutput("reset_overflow", 32'(overflow), 32'(0));
        checkOutput("reset_dout", 32'(dout), 32'(0));
        @(negedge clk25);
        rst = 1'b0;

        cpuRead(1'b1);
        checkOutput("t1_status", 32'(dout), 32'h02);

        cpuWrite(8'h41);
        cpuRead(1'b1);
        checkOutput("t2_busy_status", 32'(dout), 32'h00);
        waitTdre();
        cpuRead(1'b1);
        checkOutput("t2_idle_status", 32'(dout), 32'h02);
        checkOutput("t2_len", 32'(text_len), 32'd1);
        hostRead(2'd0);
        checkOutput("t2_host_byte", 32'(textoutput_dout), 32'h41);

        clearBuffer();
        cpuWrite(8'h41);
        cpuWrite(8'h42);
        waitTdre();
        cpuRead(1'b1);
        checkOutput("t3_status", 32'(dout), 32'h22);
        checkOutput("t3_len", 32'(text_len), 32'd1);

        clearBuffer();
        for (int i = 0; i < 5; i++) begin
            cpuWrite(8'(8'h50 + i));
            waitTdre();
        end
        checkOutput("t4_len", 32'(text_len), 32'd4);
        checkOutput("t4_overflow", 32'(overflow), 32'd1);
        hostRead(2'd3);
        checkOutput("t4_last_byte", 32'(textoutput_dout), 32'h53);

        clearBuffer();
        ioctl_upload = 1'b1;
        cpuWrite(8'h77);
        repeat (3 * DIV) stepClock();
        cpuRead(1'b1);
        checkOutput("t5_held_status", 32'(dout), 32'h00);
        checkOutput("t5_held_len", 32'(text_len), 32'd0);
        ioctl_upload = 1'b0;
        waitTdre();
        checkOutput("t5_len", 32'(text_len), 32'd1);

        clearBuffer();
        cpuWrite(8'h0D); waitTdre();
        cpuWrite(8'h0A); waitTdre();
        cpuWrite(8'h31); waitTdre();
        hostRead(2'd0);
`ifdef ASCII_OUT_CRLF_EN
        checkOutput("t6_len", 32'(text_len), 32'd2);
        checkOutput("t6_byte0", 32'(textoutput_dout), 32'h0A);
`else
        checkOutput("t6_len", 32'(text_len), 32'd3);
        checkOutput("t6_byte0", 32'(textoutput_dout), 32'h0D);
`endif
        hostRead(2'd1);
        hostRead(2'd2);

        cpuWrite(8'h55);
        cs = 1'b1; we = 1'b1; address = 1'b0; din = 8'h66; text_clear = 1'b1;
        stepClock();
        setIdle();
        checkOutput("t7_len", 32'(text_len), 32'd0);
        checkOutput("t7_overflow", 32'(overflow), 32'd0);
        cpuRead(1'b1);
        checkOutput("t7_status", 32'(dout), 32'h02);
        repeat (2 * DIV) stepClock();
        checkOutput("t7_len_after", 32'(text_len), 32'd0);

        applyStimulus(3000);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
